// File: rtl/ula_loader.sv
// Operand/opcode loader feeding an ALU: captures A, B and mode/opcode, then holds them until Ack.
// Optional macro ULA_LOADER_CHAIN_EN adds Result_in/Chain to feed the ALU result back as the next A.
module ula_loader (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Data_in,
    input  logic       Load,
    input  logic       Clear,
    input  logic       Ack,
`ifdef ULA_LOADER_CHAIN_EN
    input  logic [5:0] Result_in,
    input  logic       Chain,
`endif
    output logic [5:0] A,
    output logic [5:0] B,
    output logic       Set,
    output logic [2:0] Setop,
    output logic       Valid,
    output logic [1:0] State,
    output logic [7:0] Count
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_a;
    logic [5:0] r_b;
    logic       r_set;
    logic [2:0] r_setop;
    logic       r_valid;
    logic [7:0] r_count;

    logic       w_ld_a;
    logic       w_ld_b;
    logic       w_ld_op;
    logic       w_ack;
    logic       w_chain;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= LOAD_A;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == ISSUE);
        end
    end

    // Clear wins over Ack, Ack over Load; Load is meaningless in ISSUE.
    always_comb begin
        w_next  = r_state;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_ld_op = 1'b0;
        w_ack   = 1'b0;
        w_chain = 1'b0;
        if (Clear) begin
            w_next = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (Load) begin
                        w_ld_a = 1'b1;
                        w_next = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (Load) begin
                        w_ld_b = 1'b1;
                        w_next = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (Load) begin
                        w_ld_op = 1'b1;
                        w_next  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (Ack) begin
                        w_ack  = 1'b1;
                        w_next = LOAD_A;
`ifdef ULA_LOADER_CHAIN_EN
                        if (Chain) begin
                            w_chain = 1'b1;
                            w_next  = LOAD_B;
                        end
`endif
                    end
                end
                default: w_next = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_set   <= 1'b0;
            r_setop <= '0;
            r_count <= '0;
        end else begin
            if (w_ld_a) begin
                r_a <= Data_in;
            end
`ifdef ULA_LOADER_CHAIN_EN
            else if (w_chain) begin
                r_a <= Result_in;
            end
`endif
            if (w_ld_b) begin
                r_b <= Data_in;
            end
            if (w_ld_op) begin
                r_set   <= Data_in[3];
                r_setop <= Data_in[2:0];
            end
            if (w_ack) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign Set   = r_set;
    assign Setop = r_setop;
    assign Valid = r_valid;
    assign State = r_state;
    assign Count = r_count;

endmodule

// File: doc/ula_loader.md
ULA_LOADER -- requirements
Module: ula_loader

Interface
REQ-001 Clock  input  1  rising-edge clock for all state.
REQ-002 Reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of Clock.
REQ-003 Data_in  input  6  operand/opcode value entered by the user.
REQ-004 Load  input  1  synchronous one-cycle strobe: capture Data_in into the field selected by the current state.
REQ-005 Clear  input  1  synchronous abort; return to LOAD_A.
REQ-006 Ack  input  1  downstream ALU stage has consumed the issued operation.
REQ-007 A  output  6  registered operand A to the ALU.
REQ-008 B  output  6  registered operand B to the ALU.
REQ-009 Set  output  1  registered ALU mode select: 0 = logic, 1 = arithmetic.
REQ-010 Setop  output  3  registered ALU operation code.
REQ-011 Valid  output  1  A, B, Set and Setop form a complete operation awaiting Ack.
REQ-012 State  output  2  current FSM state encoding, for status LEDs.
REQ-013 Count  output  8  number of completed handshakes.
REQ-014 Result_in  input  6  ALU Out, fed back; present only with ULA_LOADER_CHAIN_EN.
REQ-015 Chain  input  1  load Result_in as the next A; present only with ULA_LOADER_CHAIN_EN.

Function
REQ-016 FSM states and encodings: LOAD_A=2'd0, LOAD_B=2'd1, LOAD_OP=2'd2, ISSUE=2'd3; State SHALL equal the current encoding.
REQ-017 LOAD_A with Load=1: A <= Data_in; next state LOAD_B.
REQ-018 LOAD_B with Load=1: B <= Data_in; next state LOAD_OP.
REQ-019 LOAD_OP with Load=1: Set <= Data_in[3] and Setop <= Data_in[2:0]; Data_in[5:4] ignored; next state ISSUE.
REQ-020 Any LOAD_* state with Load=0: no register change and no state change.
REQ-021 Valid SHALL be registered and equal 1 exactly while State=ISSUE; it rises on the first cycle after the LOAD_OP capture edge.
REQ-022 In ISSUE, Load SHALL be ignored, and A, B, Set and Setop SHALL remain stable until Ack.
REQ-023 In ISSUE with Ack=1: Count <= Count+1, wrapping 8'hFF -> 8'h00; next state LOAD_A, so Valid=0 on the next cycle.
REQ-024 Ack outside ISSUE SHALL be ignored; Count does not change.
REQ-025 Clear=1 in any state: next state LOAD_A and Valid=0; A, B, Set, Setop and Count retain their values.
REQ-026 Priority when inputs coincide: Clear over Ack over Load.
REQ-027 Outputs SHALL keep their last captured values after a handshake until overwritten by a new Load.
REQ-028 Throughput: at most one operation per 4 cycles (3 Load cycles plus 1 Ack cycle minimum).

Reset
REQ-029 While Reset=1: State=LOAD_A, and A, B, Set, Setop, Valid and Count are all 0.
REQ-030 Reset asserted mid-sequence, including in ISSUE, SHALL abort the operation; Valid drops without a clock edge.
REQ-031 After Reset deasserts, the first Load SHALL capture into A.

Configuration
REQ-032 Macro ULA_LOADER_CHAIN_EN defined: Result_in and Chain ports exist.
- In ISSUE with Ack=1 and Chain=1: A <= Result_in; next state LOAD_B; Count increments.
- With Chain=0: behaviour per REQ-023.
REQ-033 Macro ULA_LOADER_CHAIN_EN undefined: Result_in and Chain ports are absent, and Ack always leads to LOAD_A.

Verification
REQ-034 Basic issue: Load with Data_in = 6'd12, 6'd5, 6'b001000 -> A=12, B=5, Set=1, Setop=0, Valid=1 one cycle after the third Load, State=3.
REQ-035 Valid hold: after REQ-034, hold Ack=0 for 10 cycles while pulsing Load with 6'd63 -> Valid=1 and A/B/Set/Setop unchanged throughout; then Ack=1 -> Valid=0 next cycle, Count=1, State=0.
REQ-036 Count wrap: 256 complete handshakes -> Count goes 255 -> 0; Count unchanged by Ack pulses while in LOAD_A.
REQ-037 Clear/Ack collision: in ISSUE, assert Clear=1 and Ack=1 together -> State=0, Valid=0, Count unchanged, A=12 retained.
REQ-038 Async reset: assert Reset between clock edges while in LOAD_OP -> State=0 and all outputs 0 immediately; first Load of 6'd7 after release -> A=7.
REQ-039 Chain (ULA_LOADER_CHAIN_EN defined): in ISSUE with Result_in=6'd17, Chain=1, Ack=1 -> A=17, State=1, Count increments; next Load captures into B.
